bmem_arbiter: RTL and testbench

BMEM_ARBITER -- requirements
Module: bmem_arbiter

---
 rtl/bmem_arbiter_pkg.sv | 32 +++
 rtl/bmem_line_buf.sv | 29 ++
 rtl/bmem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_bmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_arbiter_pkg.sv
// bmem_arbiter_pkg
//   Shared types and constants for the I/D cache to burst-memory arbiter.
//   - arb_state_t : arbiter FSM states
//   - requester_t : which cache port owns the current transaction
//   - LINE_W, BURST_LEN : cache line width and beats per line
//   - line_base() : strips the byte offset from an address to get the line address
package bmem_arbiter_pkg;

  localparam int LINE_W    = 256;
  localparam int BURST_LEN = 4;

  // Byte offset within a 32-byte line.
  localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_001F;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/bmem_line_buf.sv
// bmem_line_buf
//   Cache-line assembly register, written one beat at a time.
//   Ports:
//     clk, rst : clock and synchronous active-high reset (clears the line)
//     we       : write enable for one beat
//     idx      : beat index to write
//     wdata    : beat data
//     line     : full assembled line
module bmem_line_buf #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [1:0]                  idx,
  input  logic [BEAT_W-1:0]           wdata,
  output logic [BEAT_W*BURST_LEN-1:0] line
);

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (we) begin
      line[BEAT_W*idx +: BEAT_W] <= wdata;
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter
//   Arbitrates an I-cache (read-only) and a D-cache port onto one burst
//   memory. Reads issue a single accepted request and collect BURST_LEN
//   address-tagged beats; writes stream BURST_LEN beats under bmem_ready
//   flow control. Every output is registered.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     i_dfp_*                  : I-cache line port (addr, read, rdata, resp)
//     d_dfp_*                  : D-cache line port (addr, read, write, wdata, rdata, resp)
//     bmem_addr/read/write/wdata : memory request side
//     bmem_ready/raddr/rdata/rvalid : memory response side
//   Build option:
//     ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//     between ports; otherwise the D-cache always wins.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
#(
  parameter int BURST_LEN = bmem_arbiter_pkg::BURST_LEN,
  parameter int BEAT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_dfp_addr,
  input  logic              i_dfp_read,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,
  input  logic [31:0]       d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  arb_state_t        state, state_n;
  logic [1:0]        cnt, cnt_n, cnt_inc;
  requester_t        gnt_q, gnt_n, pick;
  logic              wr_op_q, wr_op_n;
  logic [31:0]       line_addr_q, line_addr_n, pick_addr;
  logic [LINE_W-1:0] wbuf_q, wbuf_n;
  logic              d_req, i_req, beat_hit, beat_we;
  logic [LINE_W-1:0] line, assembled;

  logic              bmem_read_n, bmem_write_n, i_resp_n, d_resp_n;
  logic [31:0]       bmem_addr_n;
  logic [BEAT_W-1:0] bmem_wdata_n;
  logic [LINE_W-1:0] i_rdata_n, d_rdata_n;

`ifdef ARB_ROUND_ROBIN_EN
  requester_t        last_grant;
`endif

  bmem_line_buf #(
    .BEAT_W   (BEAT_W),
    .BURST_LEN(BURST_LEN)
  ) u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (beat_we),
    .idx  (cnt),
    .wdata(bmem_rdata),
    .line (line)
  );

  // Port selection; a simultaneous read+write on the D port counts as a write.
  always_comb begin
    d_req = d_dfp_read | d_dfp_write;
    i_req = i_dfp_read;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && i_req) begin
      pick = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else begin
      pick = d_req ? REQ_D : REQ_I;
    end
`else
    pick = d_req ? REQ_D : REQ_I;
`endif
    pick_addr = line_base((pick == REQ_D) ? d_dfp_addr : i_dfp_addr);
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so they can be registered without adding latency.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cnt_inc      = cnt + 2'd1;
    gnt_n        = gnt_q;
    wr_op_n      = wr_op_q;
    line_addr_n  = line_addr_q;
    wbuf_n       = wbuf_q;
    bmem_read_n  = 1'b0;
    bmem_write_n = 1'b0;
    bmem_addr_n  = bmem_addr;
    bmem_wdata_n = bmem_wdata;
    i_resp_n     = 1'b0;
    d_resp_n     = 1'b0;
    i_rdata_n    = i_dfp_rdata;
    d_rdata_n    = d_dfp_rdata;
    beat_we      = 1'b0;
    beat_hit     = bmem_rvalid && (bmem_raddr == line_addr_q);
    // The last beat is written into the buffer on the same edge the response
    // goes out, so the returned line merges it in directly.
    assembled                        = line;
    assembled[BEAT_W*cnt +: BEAT_W]  = bmem_rdata;

    unique case (state)
      IDLE: begin
        if (d_req || i_req) begin
          gnt_n       = pick;
          wr_op_n     = (pick == REQ_D) && d_dfp_write;
          line_addr_n = pick_addr;
          bmem_addr_n = pick_addr;
          cnt_n       = '0;
          if ((pick == REQ_D) && d_dfp_write) begin
            wbuf_n       = d_dfp_wdata;
            bmem_write_n = 1'b1;
            bmem_wdata_n = d_dfp_wdata[BEAT_W-1:0];
            state_n      = WR_BURST;
          end else begin
            bmem_read_n = 1'b1;
            state_n     = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) begin
          state_n = RD_WAIT;
        end else begin
          bmem_read_n = 1'b1;
        end
      end
      RD_WAIT: begin
        if (beat_hit) begin
          beat_we = 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt_n   = '0;
            state_n = RESP;
            if (gnt_q == REQ_D) begin
              d_resp_n  = 1'b1;
              d_rdata_n = assembled;
            end else begin
              i_resp_n  = 1'b1;
              i_rdata_n = assembled;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt_n    = '0;
            state_n  = RESP;
            d_resp_n = 1'b1;
          end else begin
            cnt_n        = cnt_inc;
            bmem_write_n = 1'b1;
            bmem_wdata_n = wbuf_q[BEAT_W*cnt_inc +: BEAT_W];
          end
        end else begin
          bmem_write_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_q       <= REQ_I;
      wr_op_q     <= 1'b0;
      line_addr_q <= '0;
      wbuf_q      <= '0;
      bmem_read   <= 1'b0;
      bmem_write  <= 1'b0;
      bmem_addr   <= '0;
      bmem_wdata  <= '0;
      i_dfp_resp  <= 1'b0;
      d_dfp_resp  <= 1'b0;
      i_dfp_rdata <= '0;
      d_dfp_rdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gnt_q       <= gnt_n;
      wr_op_q     <= wr_op_n;
      line_addr_q <= line_addr_n;
      wbuf_q      <= wbuf_n;
      bmem_read   <= bmem_read_n;
      bmem_write  <= bmem_write_n;
      bmem_addr   <= bmem_addr_n;
      bmem_wdata  <= bmem_wdata_n;
      i_dfp_resp  <= i_resp_n;
      d_dfp_resp  <= d_resp_n;
      i_dfp_rdata <= i_rdata_n;
      d_dfp_rdata <= d_rdata_n;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won the most recent grant so ties alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_I;
    end else if ((state == IDLE) && (d_req || i_req)) begin
      last_grant <= pick;
    end
  end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter
//   Directed checks of the bmem arbiter: reset state, I-cache line read,
//   stray-beat filtering with a stalled request, D-cache write burst with
//   back-pressure, simultaneous-request ordering, held request across the
//   response cycle, and reset in the middle of a read burst.
module tb_bmem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int vectors     = 0;
  int miscompares = 0;

  bmem_arbiter #(
    .BURST_LEN(4),
    .BEAT_W   (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_dfp_addr (i_dfp_addr),
    .i_dfp_read (i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata),
    .i_dfp_resp (i_dfp_resp),
    .d_dfp_addr (d_dfp_addr),
    .d_dfp_read (d_dfp_read),
    .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata),
    .d_dfp_rdata(d_dfp_rdata),
    .d_dfp_resp (d_dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and land just after the rising edge, where registered
  // outputs are stable and new inputs can be set up for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives the cache-side request inputs.
  task automatic applyStimulus(input logic i_rd, input logic [31:0] i_ad,
                               input logic d_rd, input logic d_wr,
                               input logic [31:0] d_ad, input logic [255:0] d_wd);
    i_dfp_read  = i_rd;
    i_dfp_addr  = i_ad;
    d_dfp_read  = d_rd;
    d_dfp_write = d_wr;
    d_dfp_addr  = d_ad;
    d_dfp_wdata = d_wd;
  endtask

  // Entered at the first RD_ISSUE sample point. Checks the request, accepts
  // it after ready_delay stalled cycles, returns the four beats (optionally
  // preceded at beat 1 by a stray beat) and checks the one-cycle response.
  // Leaves off at the sample point of the IDLE cycle after the response.
  task automatic serveRead(input string tag, input logic is_d, input logic [31:0] exp_addr,
                           input int ready_delay, input logic stray, input logic [255:0] line);
    checkOutput({tag, " read issued"}, 256'(bmem_read), 256'd1);
    checkOutput({tag, " addr"}, 256'(bmem_addr), 256'(exp_addr));
    bmem_ready = 1'b0;
    for (int c = 0; c < ready_delay; c++) begin
      step();
      checkOutput({tag, " read held"}, 256'(bmem_read), 256'd1);
    end
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    checkOutput({tag, " read dropped"}, 256'(bmem_read), 256'd0);
    for (int k = 0; k < 4; k++) begin
      if (stray && k == 1) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_3000;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        checkOutput({tag, " stray no resp"}, 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = line[64*k +: 64];
      step();
      if (k < 3) begin
        checkOutput({tag, " no early resp"}, 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
      end
    end
    bmem_rvalid = 1'b0;
    checkOutput({tag, " resp"}, 256'({i_dfp_resp, d_dfp_resp}), is_d ? 256'd1 : 256'd2);
    checkOutput({tag, " rdata"}, is_d ? d_dfp_rdata : i_dfp_rdata, line);
    step();
    checkOutput({tag, " resp ended"}, 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
    checkOutput({tag, " rdata held"}, is_d ? d_dfp_rdata : i_dfp_rdata, line);
    checkOutput({tag, " idle no read"}, 256'(bmem_read), 256'd0);
  endtask

  // One-shot read: request for one cycle, then scramble the inputs to show
  // they are ignored once granted.
  task automatic readTxn(input string tag, input logic is_d, input logic [31:0] addr,
                         input int ready_delay, input logic stray, input logic [255:0] line);
    if (is_d) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, addr, '0);
    else      applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0, '0);
    step();
    applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, '1);
    serveRead(tag, is_d, addr & 32'hFFFF_FFE0, ready_delay, stray, line);
  endtask

  logic [255:0] line_a, line_b, line_w, line_d, line_i, line_h1, line_h2, line_r;
  logic [63:0]  exp_w [6];
  logic         rdy_w [6];
  logic         rr_i_first;

  initial begin
    line_a  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};
    line_w  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    line_d  = {64'hD000_0000_0000_0003, 64'hD000_0000_0000_0002,
               64'hD000_0000_0000_0001, 64'hD000_0000_0000_0000};
    line_i  = {64'h1000_0000_0000_0003, 64'h1000_0000_0000_0002,
               64'h1000_0000_0000_0001, 64'h1000_0000_0000_0000};
    line_h1 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
               64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    line_h2 = {64'h7777_1111_0000_0004, 64'h7777_1111_0000_0003,
               64'h7777_1111_0000_0002, 64'h7777_1111_0000_0001};
    line_r  = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
               64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    exp_w   = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    rdy_w   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
    rr_i_first = 1'b1;
`else
    rr_i_first = 1'b0;
`endif

    // Reset state.
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    bmem_ready  = 1'b0;
    bmem_raddr  = 32'h0;
    bmem_rdata  = 64'h0;
    bmem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset bmem_read", 256'(bmem_read), 256'd0);
    checkOutput("reset bmem_write", 256'(bmem_write), 256'd0);
    checkOutput("reset bmem_addr", 256'(bmem_addr), 256'd0);
    checkOutput("reset bmem_wdata", 256'(bmem_wdata), 256'd0);
    checkOutput("reset resp", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
    checkOutput("reset i_rdata", i_dfp_rdata, 256'd0);
    checkOutput("reset d_rdata", d_dfp_rdata, 256'd0);
    step();

    // I-cache read of an unaligned address.
    readTxn("i read", 1'b0, 32'h0000_1024, 0, 1'b0, line_a);

    // Stray beat and stalled request acceptance.
    readTxn("stray", 1'b0, 32'h0000_1024, 2, 1'b1, line_b);

    // D-cache write with read also high, stalled on the second beat.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, line_w);
    bmem_ready = 1'b1;
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, '1);
    checkOutput("wr addr", 256'(bmem_addr), 256'h2000);
    for (int c = 0; c < 6; c++) begin
      checkOutput("wr active", 256'(bmem_write), 256'd1);
      checkOutput("wr beat", 256'(bmem_wdata), 256'(exp_w[c]));
      checkOutput("wr no resp", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
      bmem_ready = rdy_w[c];
      step();
    end
    bmem_ready = 1'b0;
    checkOutput("wr done", 256'(bmem_write), 256'd0);
    checkOutput("wr resp", 256'({i_dfp_resp, d_dfp_resp}), 256'd1);
    checkOutput("wr d_rdata untouched", d_dfp_rdata, 256'd0);
    step();
    checkOutput("wr resp ended", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);

    // Simultaneous reads; the second requester keeps asserting until granted.
    applyStimulus(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_5000, '0);
    step();
    if (rr_i_first) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_5000, '0);
      serveRead("arb first", 1'b0, 32'h0000_4000, 0, 1'b0, line_i);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
      serveRead("arb second", 1'b1, 32'h0000_5000, 0, 1'b0, line_d);
    end else begin
      applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0, '0);
      serveRead("arb first", 1'b1, 32'h0000_5000, 0, 1'b0, line_d);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
      serveRead("arb second", 1'b0, 32'h0000_4000, 0, 1'b0, line_i);
    end

    // Request held through the response cycle: granted again only from IDLE.
    applyStimulus(1'b1, 32'h0000_7008, 1'b0, 1'b0, 32'h0, '0);
    step();
    serveRead("held first", 1'b0, 32'h0000_7000, 0, 1'b0, line_h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    serveRead("held regrant", 1'b0, 32'h0000_7000, 1, 1'b0, line_h2);

    // Reset after two beats of a read; remaining beats arrive afterwards.
    applyStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b0, 32'h0, '0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    checkOutput("abort read issued", 256'(bmem_read), 256'd1);
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_6000;
      bmem_rdata  = 64'hEEEE_0000_0000_0000 | 64'(k);
      step();
    end
    bmem_rdata = 64'hEEEE_0000_0000_0002;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort bmem_read", 256'(bmem_read), 256'd0);
    checkOutput("abort bmem_write", 256'(bmem_write), 256'd0);
    checkOutput("abort bmem_addr", 256'(bmem_addr), 256'd0);
    checkOutput("abort bmem_wdata", 256'(bmem_wdata), 256'd0);
    checkOutput("abort resp", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
    checkOutput("abort i_rdata", i_dfp_rdata, 256'd0);
    checkOutput("abort d_rdata", d_dfp_rdata, 256'd0);
    bmem_rdata = 64'hEEEE_0000_0000_0003;
    step();
    bmem_rvalid = 1'b0;
    checkOutput("late beat resp", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
    checkOutput("late beat no read", 256'(bmem_read), 256'd0);
    step();
    checkOutput("late beat quiet", 256'({i_dfp_resp, d_dfp_resp}), 256'd0);
    readTxn("after abort", 1'b0, 32'h0000_6000, 0, 1'b0, line_r);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
